// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access. One transaction
// is in flight at a time; data has priority, fetch has a starvation guard, and a hung memory times out.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          err,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshakes: a requester holds *_req and its fields until *_ready is high (accept = req && ready);
    // mem_req is held with its fields until mem_gnt; mem_rvalid is the single response beat.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    starve_cnt;
    logic [TW-1:0] to_cnt;
    logic          owner_d;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          starve_hit;
    logic          d_win;
    logic          if_win;
    logic          timed_out;

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));
    // Data loses only to a waiting fetch that has hit the starvation limit.
    assign d_win      = d_req && !(if_req && starve_hit);
    assign if_win     = if_req && !d_win;
    assign timed_out  = (TIMEOUT != 0) && (to_cnt == TW'(TIMEOUT - 1)) && !mem_rvalid;

    always_comb begin
        state_nx = state;
        if_ready = 1'b0;
        d_ready  = 1'b0;
        mem_req  = 1'b0;
        case (state)
            IDLE: begin
                if_ready = if_win;
                d_ready  = d_win;
                if (if_win || d_win) state_nx = ISSUE;
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nx = WAIT;
            end
            WAIT: begin
                if (mem_rvalid || timed_out) state_nx = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_win || d_win) begin
                        owner_d    <= d_win;
                        lat_we     <= d_win && d_we;
                        lat_addr   <= d_win ? d_addr : if_addr;
                        lat_wdata  <= d_win ? d_wdata : '0;
                        starve_cnt <= (d_win && if_req) ? starve_cnt + 4'd1 : 4'd0;
                    end
                end
                ISSUE: to_cnt <= '0;
                WAIT: begin
                    if (mem_rvalid) begin
                        // Stores complete without touching d_rdata.
                        if (owner_d) begin
                            if (!lat_we) d_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end else if (timed_out) begin
                        err <= 1'b1;
                        if (owner_d) d_rdata <= '1;
                        else         if_rdata <= '1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_rvalid = (state == RESP) && !owner_d;
    assign d_rvalid  = (state == RESP) && owner_d;
    assign busy      = (state != IDLE);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter: a memory responder with adjustable
// grant/response delay, and a transaction-level model of arbitration, memory contents and completions.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err, busy;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  bit          grant_log[$];
  int          starve_run = 0;
  logic [31:0] model_if_rdata = '0;
  logic [31:0] model_d_rdata = '0;
  bit          pend_if = 1'b0;
  logic [31:0] pend_if_addr = '0;
  bit          pend_d = 1'b0;
  bit          pend_d_we = 1'b0;
  logic [31:0] pend_d_addr = '0;
  logic [31:0] pend_d_wdata = '0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] read_mem(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    if_req  = pend_if;
    if_addr = pend_if_addr;
    d_req   = pend_d;
    d_we    = pend_d_we;
    d_addr  = pend_d_addr;
    d_wdata = pend_d_wdata;
  endtask

  task automatic new_fetch(input logic [31:0] a);
    pend_if = 1'b1;
    pend_if_addr = a;
  endtask

  task automatic new_data(input bit we, input logic [31:0] a, input logic [31:0] wd);
    pend_d = 1'b1;
    pend_d_we = we;
    pend_d_addr = a;
    pend_d_wdata = wd;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_bit({tag, "_if_ready"}, if_ready, 1'b0);
    check_bit({tag, "_d_ready"}, d_ready, 1'b0);
    check_bit({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    check_bit({tag, "_d_rvalid"}, d_rvalid, 1'b0);
  endtask

  // One complete transaction starting with the DUT in IDLE; called at posedge+1.
  task automatic round(input int gnt_wait, input int rv_wait, input bit rv_never,
                       input bit arrive, input bit late_rv);
    bit          exp_d, timed, responded;
    logic        we_e;
    logic [31:0] a_e, w_e, resp, exp_v;
    exp_d = pend_d && !(pend_if && starve_run == STARVE_MAX);
    drive_reqs();
    @(negedge clk);
    check_bit("idle_busy", busy, 1'b0);
    check_bit("grant_if_ready", if_ready, !exp_d);
    check_bit("grant_d_ready", d_ready, exp_d);
    grant_log.push_back(d_ready);
    if (exp_d) begin
      a_e = pend_d_addr; we_e = pend_d_we; w_e = pend_d_wdata;
    end else begin
      a_e = pend_if_addr; we_e = 1'b0; w_e = '0;
    end
    starve_run = (exp_d && pend_if) ? starve_run + 1 : 0;
    if (exp_d) pend_d = 1'b0;
    else       pend_if = 1'b0;
    if (we_e) mem_arr[a_e] = w_e;
    tick();
    if (arrive) begin
      if (!pend_if && $urandom_range(0, 1) == 1) new_fetch(rand_addr());
      if (!pend_d && $urandom_range(0, 1) == 1) new_data(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
    drive_reqs();
    // ISSUE: command held until granted
    for (int n = 0; n <= gnt_wait; n++) begin
      mem_gnt = (n == gnt_wait);
      @(negedge clk);
      check_bit("issue_mem_req", mem_req, 1'b1);
      check_word("issue_mem_addr", mem_addr, a_e);
      check_bit("issue_mem_we", mem_we, we_e);
      if (exp_d) check_word("issue_mem_wdata", mem_wdata, w_e);
      check_bit("issue_busy", busy, 1'b1);
      check_idle_outputs("issue");
      tick();
    end
    mem_gnt = 1'b0;
    // WAIT: response or timeout
    responded = 1'b0;
    resp = '0;
    for (int w = 0; w < TIMEOUT; w++) begin
      mem_rvalid = !rv_never && (w == rv_wait);
      resp = we_e ? $urandom : read_mem(a_e);
      mem_rdata = mem_rvalid ? resp : $urandom;
      @(negedge clk);
      check_bit("wait_mem_req", mem_req, 1'b0);
      check_bit("wait_err", err, 1'b0);
      check_word("wait_mem_addr", mem_addr, a_e);
      check_idle_outputs("wait");
      tick();
      if (mem_rvalid) begin
        responded = 1'b1;
        mem_rvalid = 1'b0;
        break;
      end
    end
    timed = !responded;
    mem_rvalid = late_rv;
    mem_rdata = $urandom;
    if (timed)      exp_v = '1;
    else if (!exp_d) exp_v = resp;
    else if (!we_e) exp_v = resp;
    else            exp_v = model_d_rdata;
    exp_q.push_back(exp_v);
    if (exp_d) model_d_rdata = exp_v;
    else       model_if_rdata = exp_v;
    // RESP
    @(negedge clk);
    check_bit("resp_if_rvalid", if_rvalid, !exp_d);
    check_bit("resp_d_rvalid", d_rvalid, exp_d);
    check_bit("resp_err", err, timed);
    check_bit("resp_mem_req", mem_req, 1'b0);
    check_word("resp_mem_addr", mem_addr, a_e);
    check_bit("resp_mem_we", mem_we, we_e);
    if (exp_d) begin
      check_word("resp_d_rdata", d_rdata, exp_q.pop_front());
      check_word("resp_if_rdata_hold", if_rdata, model_if_rdata);
    end else begin
      check_word("resp_if_rdata", if_rdata, exp_q.pop_front());
      check_word("resp_d_rdata_hold", d_rdata, model_d_rdata);
    end
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit pat [6];
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    mem_arr[32'h100] = 32'h0050_0093;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_mem_req", mem_req, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check_word("rst_mem_addr", mem_addr, 32'h0);
    check_word("rst_mem_wdata", mem_wdata, 32'h0);
    check_word("rst_if_rdata", if_rdata, 32'h0);
    check_word("rst_d_rdata", d_rdata, 32'h0);
    check_idle_outputs("rst");
    tick();
    rst = 1'b1;
    tick();

    // fetch alone, minimum latency
    new_fetch(32'h100);
    round(0, 0, 1'b0, 1'b0, 1'b0);
    check_word("fetch_alone_rdata", if_rdata, 32'h0050_0093);

    // simultaneous: data store wins, then the waiting fetch
    new_fetch(32'h104);
    new_data(1'b1, 32'h40, 32'hCAFE_F00D);
    grant_log.delete();
    round(0, 0, 1'b0, 1'b0, 1'b0);
    round(0, 1, 1'b0, 1'b0, 1'b0);
    check_bit("simul_first_data", grant_log[0], 1'b1);
    check_bit("simul_second_fetch", grant_log[1], 1'b0);

    // load back the stored word
    new_data(1'b0, 32'h40, 32'h0);
    round(0, 0, 1'b0, 1'b0, 1'b0);
    check_word("load_after_store", d_rdata, 32'hCAFE_F00D);

    // starvation guard
    grant_log.delete();
    new_fetch(32'h200);
    for (int i = 0; i < 6; i++) begin
      if (!pend_if) new_fetch(32'h204);
      new_data(1'b0, rand_addr(), 32'h0);
      round(0, 0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) check_bit($sformatf("starve_grant%0d", i), grant_log[i], pat[i]);
    round(0, 0, 1'b0, 1'b0, 1'b0);

    // grant back-pressure: 6 ISSUE cycles
    new_fetch(32'h300);
    round(5, 0, 1'b0, 1'b0, 1'b0);

    // timeout with a late response afterwards
    new_data(1'b0, 32'h80, 32'h0);
    round(0, 0, 1'b1, 1'b0, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check_bit("timeout_busy_dropped", busy, 1'b0);
    check_bit("timeout_err_one_cycle", err, 1'b0);
    check_word("timeout_d_rdata", d_rdata, 32'hFFFF_FFFF);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_word("late_rvalid_ignored", d_rdata, 32'hFFFF_FFFF);
    tick();

    // reset asserted in WAIT
    new_fetch(32'h400);
    drive_reqs();
    @(negedge clk);
    check_bit("rstw_if_ready", if_ready, 1'b1);
    tick();
    pend_if = 1'b0;
    drive_reqs();
    mem_gnt = 1'b1;
    @(negedge clk);
    check_bit("rstw_mem_req", mem_req, 1'b1);
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    check_bit("rstw_in_wait", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_bit("rstw_async_mem_req", mem_req, 1'b0);
    check_bit("rstw_async_busy", busy, 1'b0);
    check_bit("rstw_async_if_rvalid", if_rvalid, 1'b0);
    check_bit("rstw_async_d_rvalid", d_rvalid, 1'b0);
    check_word("rstw_async_mem_addr", mem_addr, 32'h0);
    check_word("rstw_async_if_rdata", if_rdata, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b1;
    starve_run = 0;
    model_if_rdata = '0;
    model_d_rdata = '0;
    @(negedge clk);
    check_bit("rstw_after_busy", busy, 1'b0);
    check_word("rstw_after_if_rdata", if_rdata, 32'h0);
    tick();
    mem_rvalid = 1'b0;
    new_fetch(32'h500);
    round(0, 0, 1'b0, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      if (!pend_if && $urandom_range(0, 2) != 0) new_fetch(rand_addr());
      if (!pend_d && $urandom_range(0, 2) != 0) new_data(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!pend_if && !pend_d) new_fetch(rand_addr());
      round($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
            1'b1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
